// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC sequencer.
// Holds the FSM state enum, default widths and done-counter width.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    DONE
  } state_t;

  localparam int N_DEF     = 8;
  localparam int LEN_W_DEF = 8;
  localparam int CNT_W     = 16;

endpackage

// File: rtl/mac_Nbits.sv
// Signed N x N -> 2N multiply-accumulate register.
// Out clears on synchronous rst, accumulates W*X on en (wraps).
module mac_Nbits
  import mac_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   w,
  input  logic [N-1:0]   x,
  output logic [2*N-1:0] out
);

  logic signed [2*N-1:0] prod;

  assign prod = $signed(w) * $signed(x);

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else if (en) begin
      out <= out + prod;
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer around a single mac_Nbits datapath.
// Define MAC_SEQ_CNT_EN to add the done_cnt completed-job counter.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_w,
  input  logic [N-1:0]     in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_data,
  output logic             busy
`ifdef MAC_SEQ_CNT_EN
  ,output logic [CNT_W-1:0] done_cnt
`endif
);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nx;
  logic             mac_rst;
  logic             mac_en;
  logic [2*N-1:0]   acc;

  assign cnt_nx  = cnt + 1'b1;
  assign mac_rst = rst || (state == CLR);
  assign mac_en  = (state == RUN) && in_valid && in_ready;

  mac_Nbits #(
    .N(N)
  ) u_mac (
    .clk(clk),
    .rst(mac_rst),
    .en (mac_en),
    .w  (in_w),
    .x  (in_x),
    .out(acc)
  );

  // result is masked so nothing leaks while no job is being presented
  assign out_data = out_valid ? acc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            busy  <= 1'b1;
            state <= CLR;
          end
        end
        CLR: begin
          cnt <= '0;
          if (len_q == '0) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (in_valid) begin
            cnt <= cnt_nx;
            if (cnt_nx == len_q) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAC_SEQ_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (out_valid && out_ready) begin
      done_cnt <= done_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl (N=8, LEN_W=8).
// Directed jobs plus randomized jobs against a dot-product model.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_w = '0;
  logic [7:0]  in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;
`ifdef MAC_SEQ_CNT_EN
  logic [15:0] done_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int jobs_done = 0;

  logic signed [7:0] jw [16];
  logic signed [7:0] jx [16];
  int                jg [16];

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  mac_seq_ctrl #(
    .N(8),
    .LEN_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_w     (in_w),
    .in_x     (in_x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
`ifdef MAC_SEQ_CNT_EN
    ,.done_cnt(done_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, 32'(in_ready), 0);
    chk({tag, "_ov"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_od"}, 32'(out_data), 0);
  endtask

  task automatic chk_cnt(input string tag);
`ifdef MAC_SEQ_CNT_EN
    chk(tag, 32'(done_cnt), 32'(jobs_done & 16'hffff));
`else
    n_tests++;
    assert (busy === 1'b0) else begin
      n_fail++;
      $error("FAIL %s: busy got %0b expected 0", tag, busy);
    end
`endif
  endtask

  // jw/jx/jg hold the operands and pre-handshake gaps of the job
  task automatic run_job(input int l, input int rdly, input bit poke,
                         input string tag);
    int sum;
    logic [15:0] exp;
    sum = 0;
    for (int i = 0; i < l; i++) sum += int'(jw[i]) * int'(jx[i]);
    exp = 16'(sum);
    start = 1'b1;
    len = 8'(l);
    tick;
    start = 1'b0;
    len = 8'($urandom);
    chk({tag, "_clr_busy"}, 32'(busy), 1);
    chk({tag, "_clr_rdy"}, 32'(in_ready), 0);
    tick;
    if (l == 0) begin
      chk({tag, "_len0_rdy"}, 32'(in_ready), 0);
    end else begin
      chk({tag, "_run_rdy"}, 32'(in_ready), 1);
      for (int i = 0; i < l; i++) begin
        for (int g = 0; g < jg[i]; g++) begin
          in_valid = 1'b0;
          in_w = 8'($urandom);
          in_x = 8'($urandom);
          if (poke) begin
            start = 1'b1;
            len = 8'($urandom);
          end
          tick;
          start = 1'b0;
          chk({tag, "_gap_od"}, 32'(out_data), 0);
        end
        chk({tag, "_hs_rdy"}, 32'(in_ready), 1);
        in_valid = 1'b1;
        in_w = jw[i];
        in_x = jx[i];
        tick;
        in_valid = 1'b0;
      end
    end
    chk({tag, "_ov_rise"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
    chk({tag, "_done_rdy"}, 32'(in_ready), 0);
    for (int d = 0; d < rdly; d++) begin
      if (poke) start = 1'b1;
      tick;
      start = 1'b0;
      chk({tag, "_hold_ov"}, 32'(out_valid), 1);
      chk({tag, "_hold_data"}, 32'(out_data), 32'(exp));
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    jobs_done++;
    chk_idle({tag, "_end"});
    chk_cnt({tag, "_cnt"});
  endtask

  initial begin
    tick;
    tick;
    chk_idle("rst_hold");
    rst = 1'b0;
    tick;
    chk_idle("post_rst");
    chk_cnt("post_rst_cnt");

    // two back-to-back pairs: -6 + -20
    jw[0] = -3; jx[0] = 2;  jg[0] = 0;
    jw[1] = 5;  jx[1] = -4; jg[1] = 0;
    run_job(2, 0, 0, "b2b");
    run_job(2, 3, 0, "b2b_stall");

    // gapped pairs: -48 + 1 + 32
    jw[0] = 6;  jx[0] = -8; jg[0] = 2;
    jw[1] = 1;  jx[1] = 1;  jg[1] = 2;
    jw[2] = -8; jx[2] = -4; jg[2] = 2;
    run_job(3, 0, 1, "gaps");

    run_job(0, 1, 0, "len0");

    // abort mid-job, then a fresh single-element job
    start = 1'b1;
    len = 8'd3;
    tick;
    start = 1'b0;
    tick;
    in_valid = 1'b1;
    in_w = 8'd7;
    in_x = 8'd9;
    tick;
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_idle("abort");
    jobs_done = 0;
    chk_cnt("abort_cnt");
    tick;
    chk_idle("abort_idle");

    jw[0] = -128; jx[0] = -128; jg[0] = 0;
    run_job(1, 0, 0, "fresh");

    for (int i = 0; i < 3; i++) begin
      jw[i] = -128; jx[i] = -128; jg[i] = 0;
    end
    run_job(3, 2, 0, "wrap");

    for (int j = 0; j < 25; j++) begin
      int l;
      l = int'($urandom_range(0, 8));
      for (int i = 0; i < l; i++) begin
        jw[i] = 8'($urandom);
        jx[i] = 8'($urandom);
        jg[i] = int'($urandom_range(0, 3));
      end
      run_job(l, int'($urandom_range(0, 3)), 1'($urandom), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter N, default 8, operand width in bits (signed two's complement).
REQ-002 Parameter LEN_W, default 8, width of the vector-length field.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  job request; sampled only in IDLE.
REQ-006 len  in  LEN_W  unsigned element count, latched with start.
REQ-007 in_valid  in  1  operand pair valid.
REQ-008 in_ready  out  1  sequencer accepts operand pair.
REQ-009 in_w, in_x  in  N each  signed operands.
REQ-010 out_valid  out  1  dot-product result valid.
REQ-011 out_ready  in  1  result consumer ready.
REQ-012 out_data  out  2N  signed dot-product result.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, CLR, RUN and DONE.
REQ-015 IDLE: in_ready=0, out_valid=0; start=1 latches len, enters CLR; start outside IDLE SHALL be ignored.
REQ-016 CLR: exactly one cycle; drives the accumulator clear and resets the element counter; goes to DONE if latched len==0, else to RUN.
REQ-017 RUN: in_ready=1; each cycle with in_valid&&in_ready drives accumulate-enable with W=in_w and X=in_x, and the counter increments.
REQ-018 No handshake cycle in RUN SHALL leave the accumulator unchanged, with no limit on gap length.
REQ-019 The handshake that brings the accepted count to len SHALL move RUN to DONE on the same edge.
REQ-020 The first in_ready SHALL occur 2 cycles after the start edge; out_valid SHALL rise the cycle after the last handshake.
REQ-021 DONE: out_valid=1, in_ready=0; out_data SHALL hold Out + sum of in_w*in_x, stable until out_valid&&out_ready, then IDLE.
REQ-022 out_data SHALL be 0 whenever out_valid=0.
REQ-023 Accumulation SHALL be full-precision N x N -> 2N signed, wrapping modulo 2^(2N) with no saturation or flag.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE, clear the accumulator and counter, and drive in_ready=0, out_valid=0, busy=0, out_data=0.
REQ-025 rst mid-job (CLR/RUN/DONE) SHALL abort the job with no result; the next start SHALL begin a fresh job.

Configuration
REQ-026 Macro MAC_SEQ_CNT_EN defined: adds output done_cnt[15:0], reset to 0, +1 per out_valid&&out_ready, wrapping at 16 bits.
REQ-027 Macro MAC_SEQ_CNT_EN undefined: no done_cnt port or counter logic; behaviour is otherwise identical.

Structure
REQ-028 Package mac_pkg SHALL hold the FSM state enum, the N and LEN_W defaults, and the done-counter width.
REQ-029 The datapath SHALL be one instance of sub-module mac_Nbits, driven by sequencer-owned rst/en/W/X.
REQ-030 mac_Nbits: Out clears on its synchronous rst and does Out<=Out+W*X on en; the sequencer asserts its rst in CLR and on rst.

Verification (N=8)
REQ-031 len=2, pairs (-3,2),(5,-4) back-to-back -> out_valid one cycle after 2nd handshake, out_data=-26.
REQ-032 Same job, out_ready low 3 cycles -> out_valid and out_data=-26 held; handshake -> IDLE, busy=0 next cycle.
REQ-033 len=3, pairs (6,-8),(1,1),(-8,-4) with 2-cycle in_valid gaps -> out_data=-15.
REQ-034 len=0 -> CLR then DONE; out_valid 2 cycles after start, out_data=0.
REQ-035 rst in RUN after 1 pair -> IDLE next cycle, outputs 0; then len=1, (-128,-128) -> 16384.
REQ-036 len=3, three (-128,-128) pairs -> out_data=-16384 (wrap); with MAC_SEQ_CNT_EN, done_cnt increments by 1 per completed job.
